im_loader: RTL and testbench
============================

Name: im_loader

Overview:
Boot-time program loader that sits directly upstream of the 8-bit single-cycle core's instruction memory.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word into the instruction memory's write port.
- Holds the core in reset until the full image loads and its checksum verifies.
- The instruction memory gains a synchronous write port (we, addr, wdata) to receive these writes.

Parameters:
LOAD_BASE, 8'h00, first instruction-memory address written; later words increment mod 256.
TIMEOUT_CYCLES, 1024, idle cycles allowed mid-frame before abort; must be >=2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_byte holds a valid byte.
in_byte  input  8  stream byte.
in_ready  output  1  loader can accept a byte this cycle.
im_we  output  1  instruction-memory write strobe, one cycle per word.
im_addr  output  8  instruction-memory write address.
im_wdata  output  16  instruction word ({high byte, low byte}).
core_rst  output  1  drives the core's rst; high until load succeeds.
done  output  1  sticky: image loaded and checksum OK.
error  output  1  sticky: checksum mismatch or timeout.

Behaviour:
- One clock domain; reset is synchronous and active-high. clk/rst follow the core's naming.
- Reset values (after a clock edge with rst=1):
  - state S_LEN, im_we 0, im_addr 0, im_wdata 0.
  - core_rst 1, done 0, error 0, in_ready 1.
  - csum 0, timer 0.
- Handshake:
  - A byte is accepted on a rising edge when in_valid && in_ready.
  - in_ready is decoded from state only: 1 in S_LEN/S_HI/S_LO/S_CSUM, 0 in S_WR/S_DONE/S_ERR.
  - A byte offered while in_ready=0 is not consumed; the sender must hold it.
- Frame format:
  - One length byte L; word count N = L, except L=0 means N=256.
  - Then 2N data bytes, high byte first.
  - Then one checksum byte equal to the XOR of L and all 2N data bytes.
- State machine:
  - S_LEN: on accept, remaining <= N-1 (8 bits), addr <= LOAD_BASE, csum <= L -> S_HI. No timeout in S_LEN.
  - S_HI: on accept, hi <= byte, csum ^= byte -> S_LO.
  - S_LO: on accept, im_wdata <= {hi, byte}, im_addr <= addr, csum ^= byte -> S_WR.
  - S_WR (exactly 1 cycle): im_we=1. Then addr <= addr+1 (wraps 8'hFF->8'h00). If remaining==0 go to S_CSUM; else remaining <= remaining-1 and go to S_HI.
  - S_CSUM: on accept, go to S_DONE if byte==csum, else S_ERR.
  - S_DONE: done=1, core_rst=0. Sticky until rst.
  - S_ERR: error=1, core_rst=1. Sticky until rst.
- Throughput and latency:
  - One word costs at least 3 cycles (HI, LO, WR).
  - im_we rises the cycle after the low byte is accepted.
  - done and core_rst deassertion take effect the cycle after the checksum byte is accepted.
- im_we is decoded from state (high only in S_WR). im_addr and im_wdata are registered and hold their last values otherwise.
- Timeout:
  - timer counts in S_HI/S_LO/S_CSUM on cycles with no accept.
  - timer clears on accept and in every other state.
  - If timer==TIMEOUT_CYCLES-1 and no accept occurs, go to S_ERR. error is therefore high TIMEOUT_CYCLES cycles after the last accept.
- A reset mid-frame returns to S_LEN with core_rst=1. Words already written stay in instruction memory; no erase is performed.
- An accept and a timeout in the same cycle: the accept wins.

Decomposition:
- Package im_loader_pkg:
  - State enum (S_LEN, S_HI, S_LO, S_WR, S_CSUM, S_DONE, S_ERR).
  - Default LOAD_BASE / TIMEOUT_CYCLES constants.
  - Instruction-word width (16) and address width (8), shared with the core.
- One natural sub-module: im_loader_timer. Inputs: clk, rst, enable, clear. Output: expired. Parameter: TIMEOUT_CYCLES.

Test Plan:
1. Good load, LOAD_BASE=0. Stream 03,D0,00,03,D0,00,4A,4A. Expect 3 single-cycle im_we pulses writing addr0=D000, addr1=03D0, addr2=004A; then done=1, core_rst=0, error=0.
2. Bad checksum. Same frame with final byte 4B. Expect the same 3 writes, then error=1, core_rst=1, done=0, in_ready=0 thereafter.
3. Backpressure. in_valid held high with a new byte presented only after each accept. Expect in_ready=0 exactly in S_WR cycles and no byte lost or duplicated; 3 words complete in 1+9+1 accepts/write cycles.
4. Timeout, TIMEOUT_CYCLES=16. Send 02,D0 then idle. Expect error=1 exactly 16 cycles after D0 is accepted, no im_we, core_rst=1.
5. Wrap, L=00 (256 words), LOAD_BASE=8'h10. Expect 256 writes at addresses 10..FF then 00..0F, then done=1 with a correct checksum.
6. Reset mid-load. Assert rst for 1 cycle after the first word's S_WR. Expect S_LEN, core_rst=1, done=0; a following 1-word frame 01,12,34,27 writes 1234 at LOAD_BASE and sets done=1.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Word/address widths match the core's instruction memory.
package im_loader_pkg;

    localparam int unsigned IW_WIDTH = 16;
    localparam int unsigned IA_WIDTH = 8;

    localparam logic [IA_WIDTH-1:0] DEFAULT_LOAD_BASE      = 8'h00;
    localparam int unsigned         DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/im_loader_timer.sv
// Mid-frame idle timer: counts enabled cycles without a clear and flags the
// cycle on which the last permitted idle cycle would be exceeded.
module im_loader_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (enable && !clear) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // An accept in the same cycle always beats expiry.
    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/im_loader.sv
// Boot loader: assembles big-endian words from a framed byte stream, writes them
// into instruction memory and releases the core once the checksum verifies.
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [IA_WIDTH-1:0] LOAD_BASE      = DEFAULT_LOAD_BASE,
    parameter int unsigned         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [7:0]          in_byte,
    output logic                in_ready,
    output logic                im_we,
    output logic [IA_WIDTH-1:0] im_addr,
    output logic [IW_WIDTH-1:0] im_wdata,
    output logic                core_rst,
    output logic                done,
    output logic                error
);

    state_e state_q, state_d;

    logic [7:0]          remaining_q;
    logic [IA_WIDTH-1:0] addr_q;
    logic [7:0]          hi_q;
    logic [7:0]          csum_q;
    logic                accept;
    logic                timeout;
    logic                timer_en;

    assign accept   = in_valid && in_ready;
    assign timer_en = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_CSUM);

    im_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (timer_en),
        .clear  (accept),
        .expired(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LEN:   if (accept) state_d = S_HI;
            S_HI:    if (accept) state_d = S_LO; else if (timeout) state_d = S_ERR;
            S_LO:    if (accept) state_d = S_WR; else if (timeout) state_d = S_ERR;
            S_WR:    state_d = (remaining_q == 8'd0) ? S_CSUM : S_HI;
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LEN;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_LEN) || (state_q == S_HI) ||
                   (state_q == S_LO)  || (state_q == S_CSUM);
        im_we    = (state_q == S_WR);
        done     = (state_q == S_DONE);
        error    = (state_q == S_ERR);
        core_rst = (state_q != S_DONE);
    end

    // A length byte of zero wraps to 8'hFF remaining, i.e. 256 words.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= 8'd0;
            addr_q      <= '0;
            hi_q        <= 8'd0;
            csum_q      <= 8'd0;
            im_addr     <= '0;
            im_wdata    <= '0;
        end else begin
            unique case (state_q)
                S_LEN: begin
                    if (accept) begin
                        remaining_q <= in_byte - 8'd1;
                        addr_q      <= LOAD_BASE;
                        csum_q      <= in_byte;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_q   <= in_byte;
                        csum_q <= csum_q ^ in_byte;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        im_wdata <= {hi_q, in_byte};
                        im_addr  <= addr_q;
                        csum_q   <= csum_q ^ in_byte;
                    end
                end
                S_WR: begin
                    addr_q <= addr_q + 8'd1;
                    if (remaining_q != 8'd0) begin
                        remaining_q <= remaining_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a frame-level model predicts every memory write
// and the load outcome; a negedge monitor checks the DUT against it each cycle.
module tb_im_loader;
    import im_loader_pkg::*;

    localparam logic [7:0]  BASE = 8'h10;
    localparam int unsigned TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    im_loader #(
        .LOAD_BASE     (BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_byte (in_byte),
        .in_ready(in_ready),
        .im_we   (im_we),
        .im_addr (im_addr),
        .im_wdata(im_wdata),
        .core_rst(core_rst),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          wr_count    = 0;
    bit          check_en    = 1'b0;
    wr_t         exp_q[$];
    wr_t         w_exp;
    logic [7:0]  frame[$];
    logic        exp_good;
    int          exp_words;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor against the model's pending-write queue and invariants.
    always @(negedge clk) begin
        if (check_en) begin
            if (im_we === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("im_we with no pending word", im_we, 1'b0);
                end else begin
                    w_exp = exp_q.pop_front();
                    check("im_addr", im_addr, w_exp.addr);
                    check("im_wdata", im_wdata, w_exp.data);
                end
            end
            check("in_ready", in_ready, !(im_we || done || error));
            check("core_rst", core_rst, !done);
            check("done_and_error", done & error, 1'b0);
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_state();
        check("rst in_ready", in_ready, 1'b1);
        check("rst im_we", im_we, 1'b0);
        check("rst im_addr", im_addr, 8'h00);
        check("rst im_wdata", im_wdata, 16'h0000);
        check("rst core_rst", core_rst, 1'b1);
        check("rst done", done, 1'b0);
        check("rst error", error, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept wait", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Model: parse the frame, queue the writes it implies, and predict the outcome.
    task automatic model_frame();
        logic [7:0] x;
        exp_words = (frame[0] == 8'h00) ? 256 : int'(frame[0]);
        x = frame[0];
        for (int i = 0; i < exp_words; i++) begin
            exp_q.push_back('{addr: 8'(int'(BASE) + i), data: {frame[1 + 2 * i], frame[2 + 2 * i]}});
            x = x ^ frame[1 + 2 * i] ^ frame[2 + 2 * i];
        end
        exp_good = (frame[1 + 2 * exp_words] == x);
        wr_count = 0;
    endtask

    task automatic run_frame();
        model_frame();
        foreach (frame[i]) send_byte(frame[i]);
        check("frame done", done, exp_good);
        check("frame error", error, !exp_good);
        check("frame core_rst", core_rst, !exp_good);
        check("frame in_ready", in_ready, 1'b0);
        check("frame writes left", exp_q.size(), 0);
        check("frame write count", wr_count, exp_words);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;

        // 1 + 3: good load with continuous valid; 11 accept/write cycles for 3 words
        do_reset();
        check_en = 1'b1;
        check_reset_state();
        frame = '{8'h03, 8'hD0, 8'h00, 8'h03, 8'hD0, 8'h00, 8'h4A, 8'h4A};
        start = cyc;
        run_frame();
        check("t1 cycles", cyc - start, 11);
        check("t1 done", done, 1'b1);
        check("t1 last addr", im_addr, 8'h12);
        check("t1 last data", im_wdata, 16'h004A);
        check("t1 writes", wr_count, 3);

        // 2: bad checksum, then offered bytes must be ignored
        do_reset();
        check_reset_state();
        frame = '{8'h03, 8'hD0, 8'h00, 8'h03, 8'hD0, 8'h00, 8'h4A, 8'h4B};
        run_frame();
        check("t2 error", error, 1'b1);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t2 error sticky", error, 1'b1);
        check("t2 in_ready", in_ready, 1'b0);
        check("t2 core_rst", core_rst, 1'b1);

        // 4: no timeout while waiting for length; timeout exactly TMO cycles after D0
        do_reset();
        repeat (3 * TMO) @(posedge clk);
        #1;
        check("t4 no timeout in S_LEN", error, 1'b0);
        send_byte(8'h02);
        send_byte(8'hD0);
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            if (k == TMO - 1) check("t4 error before timeout", error, 1'b0);
            if (k == TMO)     check("t4 error at timeout", error, 1'b1);
        end
        check("t4 core_rst", core_rst, 1'b1);

        // 5: 256-word frame wrapping the address from FF to 00
        do_reset();
        frame.delete();
        frame.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            frame.push_back(8'(i));
            frame.push_back(~8'(i));
        end
        frame.push_back(8'h00);
        run_frame();
        check("t5 done", done, 1'b1);
        check("t5 last addr", im_addr, 8'h0F);
        check("t5 last data", im_wdata, 16'hFF00);
        check("t5 writes", wr_count, 256);

        // 6: reset right after the first word's write, then a 1-word frame
        do_reset();
        frame = '{8'h03, 8'hD0, 8'h00, 8'h03, 8'hD0, 8'h00, 8'h4A, 8'h4A};
        model_frame();
        send_byte(8'h03);
        send_byte(8'hD0);
        send_byte(8'h00);
        @(posedge clk); #1;
        check("t6 first write", wr_count, 1);
        do_reset();
        check_reset_state();
        frame = '{8'h01, 8'h12, 8'h34, 8'h27};
        run_frame();
        check("t6 done", done, 1'b1);
        check("t6 addr", im_addr, 8'h10);
        check("t6 data", im_wdata, 16'h1234);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
